// File: rtl/uart_alu_interface.sv
// uart_alu_interface: collects A, B and opcode bytes from UART RX,
// sends ALU result to TX. Option: UART_ALU_IF_STATUS_BYTE_EN.
module uart_alu_interface #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_alu_overflow,
    output logic [NB_DATA-1:0] o_alu_dataA,
    output logic [NB_DATA-1:0] o_alu_dataB,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        TX_RES,
        WAIT_RES
`ifdef UART_ALU_IF_STATUS_BYTE_EN
        ,
        TX_STAT,
        WAIT_STAT
`endif
    } state_t;

    state_t state;

`ifdef UART_ALU_IF_STATUS_BYTE_EN
    logic ovf_q;
    logic [NB_DATA-1:0] status_byte;

    // zero flag is taken from the result still held in o_tx_data
    assign status_byte = {{(NB_DATA-2){1'b0}},
                          (o_tx_data == '0), ovf_q};
`else
    logic unused_ovf;
    assign unused_ovf = i_alu_overflow;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= WAIT_A;
            o_alu_dataA <= '0;
            o_alu_dataB <= '0;
            o_alu_op    <= '0;
            o_tx_data   <= '0;
            o_tx_start  <= 1'b0;
            o_busy      <= 1'b0;
`ifdef UART_ALU_IF_STATUS_BYTE_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            o_tx_start <= 1'b0;
            unique case (state)
                WAIT_A: if (i_rx_done) begin
                    o_alu_dataA <= i_rx_data;
                    o_busy      <= 1'b1;
                    state       <= WAIT_B;
                end
                WAIT_B: if (i_rx_done) begin
                    o_alu_dataB <= i_rx_data;
                    state       <= WAIT_OP;
                end
                WAIT_OP: if (i_rx_done) begin
                    o_alu_op <= i_rx_data[NB_OP-1:0];
                    state    <= EXEC;
                end
                EXEC: begin
                    o_tx_data <= i_alu_result;
`ifdef UART_ALU_IF_STATUS_BYTE_EN
                    ovf_q     <= i_alu_overflow;
`endif
                    state     <= TX_RES;
                end
                TX_RES: begin
                    o_tx_start <= 1'b1;
                    state      <= WAIT_RES;
                end
                WAIT_RES: if (i_tx_done) begin
`ifdef UART_ALU_IF_STATUS_BYTE_EN
                    state  <= TX_STAT;
`else
                    o_busy <= 1'b0;
                    state  <= WAIT_A;
`endif
                end
`ifdef UART_ALU_IF_STATUS_BYTE_EN
                TX_STAT: begin
                    o_tx_data  <= status_byte;
                    o_tx_start <= 1'b1;
                    state      <= WAIT_STAT;
                end
                WAIT_STAT: if (i_tx_done) begin
                    o_busy <= 1'b0;
                    state  <= WAIT_A;
                end
`endif
                default: state <= WAIT_A;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_interface.sv
// tb_uart_alu_interface: randomized self-checking bench with an
// ALU stub and a byte-level reference model.
module tb_uart_alu_interface;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic       i_tx_done;
    logic [7:0] i_alu_result;
    logic       i_alu_overflow;
    logic [7:0] o_alu_dataA;
    logic [7:0] o_alu_dataB;
    logic [5:0] o_alu_op;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;

    int errors = 0;
    int checks = 0;

    uart_alu_interface #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_rx_data(i_rx_data),
        .i_rx_done(i_rx_done),
        .i_tx_done(i_tx_done),
        .i_alu_result(i_alu_result),
        .i_alu_overflow(i_alu_overflow),
        .o_alu_dataA(o_alu_dataA),
        .o_alu_dataB(o_alu_dataB),
        .o_alu_op(o_alu_op),
        .o_tx_data(o_tx_data),
        .o_tx_start(o_tx_start),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // behavioural ALU: {overflow, result}
    function automatic logic [8:0] alu_f(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [5:0] op
    );
        logic [7:0] r;
        logic       v;
        r = 8'h00;
        v = 1'b0;
        case (op)
            6'h20: begin
                r = a + b;
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            6'h22: begin
                r = a - b;
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h02: r = a >> b[2:0];
            6'h03: r = 8'($signed(a) >>> b[2:0]);
            default: r = 8'h00;
        endcase
        return {v, r};
    endfunction

    always_comb begin
        {i_alu_overflow, i_alu_result} =
            alu_f(o_alu_dataA, o_alu_dataB, o_alu_op);
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge i_clk);
        i_rx_done = 1'b0;
        i_rx_data = 8'h00;
    endtask

    // wait for a start pulse, check byte and latency, then ack
    task automatic expect_tx(
        input logic [7:0] exp,
        input string      name,
        input int         lat,
        input bit         inject
    );
        int  k;
        bit  seen;
        seen = 1'b0;
        for (k = 1; k <= 20; k++) begin
            @(negedge i_clk);
            if (o_tx_start) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s start: none in 20 cycles", name);
            return;
        end
        checks++;
        if (k !== lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d",
                     name, k, lat);
        end
        checks++;
        if (o_tx_data !== exp) begin
            errors++;
            $display("FAIL %s data: got %h want %h",
                     name, o_tx_data, exp);
        end
        if (inject) send_byte(8'hAA);
        else @(negedge i_clk);
        checks++;
        if (o_tx_start !== 1'b0 || o_tx_data !== exp ||
            o_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s hold: start=%b data=%h busy=%b want 0 %h 1",
                     name, o_tx_start, o_tx_data, o_busy, exp);
        end
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            if (o_tx_start || o_busy) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s quiet: got start/busy high want idle",
                     name);
        end
    endtask

    task automatic run_txn(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [7:0] opb,
        input string      name,
        input bit         inject
    );
        logic [8:0] ref_r;
        logic [7:0] stat;
        ref_r = alu_f(a, b, opb[5:0]);
        stat  = {6'b0, ref_r[7:0] == 8'h00, ref_r[8]};
        send_byte(a);
        checks++;
        if (o_busy !== 1'b1 || o_alu_dataA !== a) begin
            errors++;
            $display("FAIL %s capA: busy=%b A=%h want 1 %h",
                     name, o_busy, o_alu_dataA, a);
        end
        send_byte(b);
        send_byte(opb);
        checks++;
        if (o_alu_dataB !== b || o_alu_op !== opb[5:0]) begin
            errors++;
            $display("FAIL %s capB/op: B=%h op=%h want %h %h",
                     name, o_alu_dataB, o_alu_op, b, opb[5:0]);
        end
        expect_tx(ref_r[7:0], name, 2, inject);
`ifdef UART_ALU_IF_STATUS_BYTE_EN
        expect_tx(stat, {name, "_stat"}, 1, 1'b0);
`endif
        checks++;
        if (o_busy !== 1'b0 || o_alu_dataA !== a) begin
            errors++;
            $display("FAIL %s end: busy=%b A=%h want 0 %h",
                     name, o_busy, o_alu_dataA, a);
        end
`ifndef UART_ALU_IF_STATUS_BYTE_EN
        check_quiet(name);
`endif
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (o_alu_dataA !== 8'h00 || o_alu_dataB !== 8'h00 ||
            o_alu_op !== 6'h00 || o_tx_data !== 8'h00 ||
            o_tx_start !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: A=%h B=%h op=%h tx=%h st=%b bz=%b want 0",
                     name, o_alu_dataA, o_alu_dataB, o_alu_op,
                     o_tx_data, o_tx_start, o_busy);
        end
    endtask

    task automatic test_reset;
        i_reset   = 1'b1;
        i_rx_data = 8'h00;
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        repeat (3) @(negedge i_clk);
        check_zero("reset_hold");
        i_reset = 1'b0;
        @(negedge i_clk);
        check_zero("reset_release");
    endtask

    task automatic test_add;
        run_txn(8'h05, 8'h03, 8'h20, "add", 1'b0);
    endtask

    task automatic test_overflow;
        run_txn(8'h7F, 8'h01, 8'h20, "ovf", 1'b0);
    endtask

    task automatic test_sub_zero;
        run_txn(8'h0F, 8'h0F, 8'h22, "sub_zero", 1'b0);
    endtask

    task automatic test_op_mask;
        run_txn(8'hF0, 8'h0F, 8'hE5, "op_mask", 1'b0);
    endtask

    task automatic test_ignore_rx;
        run_txn(8'h11, 8'h22, 8'h20, "ignore_rx", 1'b1);
        run_txn(8'h30, 8'h0C, 8'h26, "after_ignore", 1'b0);
    endtask

    task automatic test_reset_mid;
        send_byte(8'h12);
        send_byte(8'h34);
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        check_zero("reset_mid");
        i_reset = 1'b0;
        check_quiet("reset_mid");
        check_zero("reset_mid_after");
        run_txn(8'h02, 8'h02, 8'h20, "post_reset", 1'b0);
    endtask

    task automatic test_random;
        logic [5:0] ops [8];
        logic [1:0] hi;
        logic [7:0] a;
        logic [7:0] b;
        ops = '{6'h20, 6'h22, 6'h24, 6'h25,
                6'h26, 6'h27, 6'h02, 6'h03};
        for (int i = 0; i < 16; i++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            hi = 2'($urandom_range(0, 3));
            run_txn(a, b, {hi, ops[$urandom_range(0, 7)]},
                    "random", 1'b0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_add;
        test_overflow;
        test_sub_zero;
        test_op_mask;
        test_ignore_rx;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
- Sequencer between the UART RX/TX byte engines and the combinational ALU.
- Collects three received bytes in order (operand A, operand B, opcode) and holds them on the ALU inputs.
- Registers the ALU result and hands it to the UART transmitter through a start/done handshake.
- It is the reply end of the link: bytes arrive from the host, are computed, and the result goes back to the host.

Parameters:
- NB_DATA, 8, width of operands, result and UART byte.
- NB_OP, 6, width of the ALU opcode; taken from the low NB_OP bits of the opcode byte.

Ports:
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_rx_data  in  NB_DATA  received byte; valid only while i_rx_done is high.
- i_rx_done  in  1  one-cycle strobe: RX byte complete.
- i_tx_done  in  1  one-cycle strobe: TX finished sending the current byte.
- i_alu_result  in  NB_DATA  ALU result (combinational from o_alu_*).
- i_alu_overflow  in  1  ALU signed-overflow flag.
- o_alu_dataA  out  NB_DATA  registered operand A to the ALU.
- o_alu_dataB  out  NB_DATA  registered operand B to the ALU.
- o_alu_op  out  NB_OP  registered opcode to the ALU.
- o_tx_data  out  NB_DATA  byte for the transmitter; stable from o_tx_start until i_tx_done.
- o_tx_start  out  1  one-cycle request to the transmitter.
- o_busy  out  1  high in every state except WAIT_A.

Behaviour:
- Reset (async, any state):
  - state=WAIT_A.
  - o_alu_dataA, o_alu_dataB, o_tx_data = 0; o_alu_op = 0; o_tx_start = 0; o_busy = 0.
  - Internal overflow latch = 0.
  - A transaction in progress is discarded; no partial byte is ever sent.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, TX_RES, WAIT_RES, plus TX_STAT and WAIT_STAT when the optional feature is compiled in.
- WAIT_A: on i_rx_done, o_alu_dataA <= i_rx_data, go to WAIT_B.
- WAIT_B: on i_rx_done, o_alu_dataB <= i_rx_data, go to WAIT_OP.
- WAIT_OP: on i_rx_done, o_alu_op <= i_rx_data[NB_OP-1:0] (upper bits dropped), go to EXEC.
- Opcode validity is not checked; unknown codes pass to the ALU unchanged, and its default result is transmitted.
- EXEC (exactly one cycle, lets the ALU settle): o_tx_data <= i_alu_result; overflow latch <= i_alu_overflow; go to TX_RES.
- TX_RES: o_tx_start = 1 for this single cycle; go to WAIT_RES.
- WAIT_RES: hold o_tx_data. On i_tx_done: go to WAIT_A, or to TX_STAT if the feature is enabled.
- Latency: opcode i_rx_done sampled at edge N → o_tx_data valid after edge N+1 → o_tx_start high during the cycle after edge N+2.
- i_rx_done in EXEC/TX_*/WAIT_* states: ignored; the byte is lost and not buffered.
- i_tx_done outside the WAIT_* states: ignored.
- i_tx_done in the same cycle as the TX_* state: ignored. Only WAIT_* states consume it.
- o_alu_* hold their values after a transaction until overwritten by the next A/B/opcode capture.
- i_rx_done and i_tx_done high together: each is evaluated only against the current state; at most one is acted on.

Optional Feature:
- Macro: UART_ALU_IF_STATUS_BYTE_EN.
- Defined: after the result byte is acknowledged, the block sends a second byte.
  - TX_STAT: o_tx_data <= status byte, o_tx_start = 1 for one cycle, go to WAIT_STAT.
  - WAIT_STAT: on i_tx_done, go to WAIT_A.
  - Status byte: bit0 = latched overflow, bit1 = (latched result == 0), bits 7..2 = 0.
- Undefined: TX_STAT and WAIT_STAT do not exist; exactly one byte is sent per transaction and the overflow latch may be optimised away.

Test Plan:
- RX 0x05, 0x03, 0x20 → o_alu_op=6'b100000; o_tx_start pulses 2 cycles after the opcode strobe with o_tx_data=0x08; after i_tx_done, o_busy=0.
- RX 0x7F, 0x01, 0x20 with UART_ALU_IF_STATUS_BYTE_EN → first byte 0x80, then second byte 0x01 (overflow). Without the macro: only 0x80 is sent.
- RX 0x0F, 0x0F, 0x22 (SUB) with macro → bytes 0x00 then 0x02 (zero flag).
- RX opcode byte 0xE5 → o_alu_op=6'b100101 (OR); with A=0xF0, B=0x0F → o_tx_data=0xFF.
- Extra i_rx_done (0xAA) during WAIT_RES → ignored; o_alu_dataA is unchanged and the next transaction starts cleanly at WAIT_A.
- Assert i_reset after A and B are received → all outputs 0, state WAIT_A, no o_tx_start; a following full transaction 0x02, 0x02, 0x20 → 0x04.
